// File: rtl/mantissa_align_adder.sv
// mantissa_align_adder
// Second stage of the single-precision floating-point adder. Orders the two
// unpacked operands by magnitude, aligns the smaller mantissa to the larger
// exponent, and performs the effective add or subtract. The raw sign, exponent,
// mantissa and carry are registered for the normalize/round stage.
//
// Build option: define MANT_ALIGN_STICKY_EN to jam any bits shifted out of the
// small mantissa into bit 0 of the aligned value (sticky). Without it the
// shifted-out bits are simply truncated.

module mantissa_align_adder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        S_A,
    input  logic        S_B,
    input  logic [7:0]  E_A,
    input  logic [7:0]  E_B,
    input  logic [23:0] M_A,
    input  logic [23:0] M_B,
    output logic        S_Result,
    output logic [7:0]  E_Result,
    output logic [23:0] M_Result,
    output logic        Carry
);

    logic        a_is_large;
    logic        s_large;
    logic [7:0]  e_large;
    logic [7:0]  e_small;
    logic [23:0] m_large;
    logic [23:0] m_small;
    logic [7:0]  shift_amt;
    logic [23:0] aligned_raw;
    logic [23:0] aligned;
    logic [24:0] sum_ext;
    logic [23:0] diff;
    logic        next_s;
    logic [7:0]  next_e;
    logic [23:0] next_m;
    logic        next_c;

`ifdef MANT_ALIGN_STICKY_EN
    logic [23:0] lost_mask;
    logic        lost_bits;
`endif

    // Pick the larger-magnitude operand; exponent decides first, then mantissa, A wins ties
    always_comb begin
        a_is_large = (E_A > E_B) || ((E_A == E_B) && (M_A >= M_B));
        if (a_is_large) begin
            s_large = S_A;
            e_large = E_A;
            e_small = E_B;
            m_large = M_A;
            m_small = M_B;
        end else begin
            s_large = S_B;
            e_large = E_B;
            e_small = E_A;
            m_large = M_B;
            m_small = M_A;
        end
    end

    // Shift the small mantissa right by the exponent difference, zero-filled
    always_comb begin
        shift_amt   = e_large - e_small;
        aligned_raw = 24'd0;
        if (shift_amt < 8'd24) begin
            aligned_raw = m_small >> shift_amt;
        end
    end

`ifdef MANT_ALIGN_STICKY_EN
    // Collapse every shifted-out bit into bit 0 so rounding later sees them
    always_comb begin
        lost_mask = 24'd0;
        lost_bits = 1'b0;
        if (shift_amt >= 8'd24) begin
            lost_bits = |m_small;
        end else begin
            lost_mask = (24'd1 << shift_amt) - 24'd1;
            lost_bits = |(m_small & lost_mask);
        end
        aligned = aligned_raw | {23'd0, lost_bits};
    end
`else
    // Plain truncation: shifted-out bits are discarded
    always_comb begin
        aligned = aligned_raw;
    end
`endif

    // Effective add or subtract; a zero difference is forced to positive zero
    always_comb begin
        sum_ext = {1'b0, m_large} + {1'b0, aligned};
        diff    = m_large - aligned;
        next_e  = e_large;
        if (S_A == S_B) begin
            next_s = S_A;
            next_m = sum_ext[23:0];
            next_c = sum_ext[24];
        end else begin
            next_m = diff;
            next_c = 1'b0;
            next_s = (diff == 24'd0) ? 1'b0 : s_large;
        end
    end

    // Output registers; reset has priority and discards any in-flight result
    always_ff @(posedge Clk) begin
        if (Reset) begin
            S_Result <= 1'b0;
            E_Result <= 8'h00;
            M_Result <= 24'h000000;
            Carry    <= 1'b0;
        end else begin
            S_Result <= next_s;
            E_Result <= next_e;
            M_Result <= next_m;
            Carry    <= next_c;
        end
    end

endmodule

// File: tb/tb_mantissa_align_adder.sv
// tb_mantissa_align_adder
// Directed table vectors, reset sequences and randomized vectors checked
// against an arithmetic reference model of the alignment adder. Honors
// MANT_ALIGN_STICKY_EN the same way as the design.

module tb_mantissa_align_adder;

    logic        Clk;
    logic        Reset;
    logic        S_A;
    logic        S_B;
    logic [7:0]  E_A;
    logic [7:0]  E_B;
    logic [23:0] M_A;
    logic [23:0] M_B;
    logic        S_Result;
    logic [7:0]  E_Result;
    logic [23:0] M_Result;
    logic        Carry;

    int total_checks;
    int passed_checks;

    typedef struct {
        string       name;
        logic        s_a;
        logic        s_b;
        logic [7:0]  e_a;
        logic [7:0]  e_b;
        logic [23:0] m_a;
        logic [23:0] m_b;
        logic        exp_s;
        logic [7:0]  exp_e;
        logic [23:0] exp_m;
        logic        exp_c;
    } vec_t;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [23:0] m;
        logic        c;
    } result_t;

    vec_t vecs[5];

    mantissa_align_adder dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .S_A      (S_A),
        .S_B      (S_B),
        .E_A      (E_A),
        .E_B      (E_B),
        .M_A      (M_A),
        .M_B      (M_B),
        .S_Result (S_Result),
        .E_Result (E_Result),
        .M_Result (M_Result),
        .Carry    (Carry)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic vec_t mkVec(input string name, input logic sa, input logic sb,
                                   input logic [7:0] ea, input logic [7:0] eb,
                                   input logic [23:0] ma, input logic [23:0] mb,
                                   input logic es, input logic [7:0] ee,
                                   input logic [23:0] em, input logic ec);
        vec_t v;
        v.name = name;
        v.s_a = sa;  v.s_b = sb;
        v.e_a = ea;  v.e_b = eb;
        v.m_a = ma;  v.m_b = mb;
        v.exp_s = es; v.exp_e = ee; v.exp_m = em; v.exp_c = ec;
        return v;
    endfunction

    // Reference model: magnitude ordering, division-based alignment, integer add/sub
    function automatic result_t refModel(input logic sa, input logic sb,
                                         input logic [7:0] ea, input logic [7:0] eb,
                                         input logic [23:0] ma, input logic [23:0] mb);
        result_t r;
        longint  ml, ms, al, pow, total;
        int      el, es, d;
        logic    sl, lost;
        if ((int'(ea) > int'(eb)) || ((ea == eb) && (ma >= mb))) begin
            sl = sa; el = int'(ea); es = int'(eb); ml = longint'(ma); ms = longint'(mb);
        end else begin
            sl = sb; el = int'(eb); es = int'(ea); ml = longint'(mb); ms = longint'(ma);
        end
        d = el - es;
        if (d >= 24) begin
            al   = 0;
            lost = (ms != 0);
        end else begin
            pow  = longint'(1) << d;
            al   = ms / pow;
            lost = ((ms % pow) != 0);
        end
`ifdef MANT_ALIGN_STICKY_EN
        if (lost && (al % 2 == 0)) al = al + 1;
`else
        if (lost) al = al;
`endif
        r.e = el[7:0];
        if (sa == sb) begin
            total = ml + al;
            r.s = sa;
            r.m = 24'(total % 64'd16777216);
            r.c = (total >= 64'd16777216);
        end else begin
            total = ml - al;
            r.m = 24'(total);
            r.c = 1'b0;
            r.s = (total == 0) ? 1'b0 : sl;
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic rst, input logic sa, input logic sb,
                                 input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [23:0] ma, input logic [23:0] mb);
        @(negedge Clk);
        Reset = rst;
        S_A = sa; S_B = sb;
        E_A = ea; E_B = eb;
        M_A = ma; M_B = mb;
    endtask

    task automatic compareField(input string name, input string field,
                                input logic [23:0] actual, input logic [23:0] expected);
        total_checks++;
        if (actual === expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s.%s: got %h, required %h", name, field, actual, expected);
        end
    endtask

    // Sample one time unit after the rising edge
    task automatic checkOutput(input string name, input logic es, input logic [7:0] ee,
                               input logic [23:0] em, input logic ec);
        @(posedge Clk);
        #1;
        compareField(name, "S_Result", {23'd0, S_Result}, {23'd0, es});
        compareField(name, "E_Result", {16'd0, E_Result}, {16'd0, ee});
        compareField(name, "M_Result", M_Result, em);
        compareField(name, "Carry",    {23'd0, Carry},    {23'd0, ec});
    endtask

    initial begin
        result_t     r;
        logic        sa, sb;
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb;
        logic [23:0] shift_exp;
        int          sel;

        total_checks  = 0;
        passed_checks = 0;

`ifdef MANT_ALIGN_STICKY_EN
        shift_exp = 24'h800001;
`else
        shift_exp = 24'h800000;
`endif
        vecs[0] = mkVec("opp_sign_b_larger", 1'b0, 1'b1, 8'd30, 8'd50, 24'h800000, 24'hFFFFFF,
                        1'b1, 8'd50, 24'hFFFFF7, 1'b0);
        vecs[1] = mkVec("same_sign_overflow", 1'b0, 1'b0, 8'd100, 8'd100, 24'h800000, 24'h800000,
                        1'b0, 8'd100, 24'h000000, 1'b1);
        vecs[2] = mkVec("exact_cancel", 1'b0, 1'b1, 8'd127, 8'd127, 24'hC00000, 24'hC00000,
                        1'b0, 8'd127, 24'h000000, 1'b0);
        vecs[3] = mkVec("a_larger_negative", 1'b1, 1'b0, 8'd5, 8'd3, 24'h800000, 24'h800000,
                        1'b1, 8'd5, 24'h600000, 1'b0);
        vecs[4] = mkVec("shift_ge_24", 1'b0, 1'b0, 8'd10, 8'd40, 24'hFFFFFF, 24'h800000,
                        1'b0, 8'd40, shift_exp, 1'b0);

        Reset = 1'b1;
        S_A = 1'b0; S_B = 1'b0; E_A = 8'd0; E_B = 8'd0; M_A = 24'd0; M_B = 24'd0;

        // Reset held with scenario-1 inputs: outputs stay zero
        applyStimulus(1'b1, vecs[0].s_a, vecs[0].s_b, vecs[0].e_a, vecs[0].e_b, vecs[0].m_a, vecs[0].m_b);
        checkOutput("reset_hold_0", 1'b0, 8'h00, 24'h000000, 1'b0);
        checkOutput("reset_hold_1", 1'b0, 8'h00, 24'h000000, 1'b0);

        // Release reset: result appears after exactly one edge
        applyStimulus(1'b0, vecs[0].s_a, vecs[0].s_b, vecs[0].e_a, vecs[0].e_b, vecs[0].m_a, vecs[0].m_b);
        checkOutput("reset_release", vecs[0].exp_s, vecs[0].exp_e, vecs[0].exp_m, vecs[0].exp_c);

        // One-cycle reset pulse mid-stream clears outputs at that edge
        applyStimulus(1'b1, vecs[1].s_a, vecs[1].s_b, vecs[1].e_a, vecs[1].e_b, vecs[1].m_a, vecs[1].m_b);
        checkOutput("reset_pulse", 1'b0, 8'h00, 24'h000000, 1'b0);
        applyStimulus(1'b0, vecs[1].s_a, vecs[1].s_b, vecs[1].e_a, vecs[1].e_b, vecs[1].m_a, vecs[1].m_b);
        checkOutput("after_pulse", vecs[1].exp_s, vecs[1].exp_e, vecs[1].exp_m, vecs[1].exp_c);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, vecs[i].s_a, vecs[i].s_b, vecs[i].e_a, vecs[i].e_b, vecs[i].m_a, vecs[i].m_b);
            checkOutput(vecs[i].name, vecs[i].exp_s, vecs[i].exp_e, vecs[i].exp_m, vecs[i].exp_c);
        end

        // Randomized vectors against the reference model
        for (int i = 0; i < 300; i++) begin
            sa  = 1'($urandom);
            sb  = 1'($urandom);
            ea  = 8'($urandom);
            ma  = 24'($urandom) | 24'h800000;
            mb  = 24'($urandom) | 24'h800000;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: eb = ea;
                1: eb = ea + 8'($urandom_range(0, 30));
                2: eb = ea - 8'($urandom_range(0, 30));
                default: eb = 8'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) mb = ma;
            r = refModel(sa, sb, ea, eb, ma, mb);
            applyStimulus(1'b0, sa, sb, ea, eb, ma, mb);
            checkOutput($sformatf("rand_%0d", i), r.s, r.e, r.m, r.c);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
